multiplexed_display_driver: RTL

Parametrised multiplexed seven-segment driver, the successor to the fixed 8-digit/16-bit controller. It scans DIGITS common-anode digits with active-low segment and digit enables, and adds per-digit decimal points and a per-digit blank mask. Further additions are leading-zero suppression, 16-level global brightness by PWM within each digit slot, an anti-ghost blank tick, and a frame-synchronous shadow latch so the display never tears mid-frame. It sits between user logic (switches, counters) and the board's display pins.

---
 rtl/multiplexed_display_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/multiplexed_display_driver.sv
// Multiplexed seven-segment scanner: common-anode, active-low pins, PWM brightness
// within each digit slot, leading-zero suppression and a frame-synchronous shadow latch.
module multiplexed_display_driver #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 781
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     pointEnable,
    input  logic [DIGITS-1:0]     digitMask,
    input  logic                  suppressLeadingZeros,
    input  logic [3:0]            brightness,
    output logic [7:0]            segmentEnableN,
    output logic [DIGITS-1:0]     digitEnableN,
    output logic                  frameStart
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0]          slot_q, slot_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic                load_pend_q, load_pend_d;
    logic                frame_start_q, frame_start_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   den_q, den_d;

    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_point_q, sh_point_d;
    logic [DIGITS-1:0]   sh_mask_q, sh_mask_d;
    logic                sh_supp_q, sh_supp_d;
    logic [3:0]          sh_bright_q, sh_bright_d;

    logic                tick;
    logic                frame_wrap;
    logic                load;
    logic [DIGITS-1:0]   suppressed;
    logic                lead;
    logic [3:0]          cur_nib;
    logic                cur_pt;
    logic                cur_dark;
    logic                slot_lit;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q       <= '0;
            slot_q        <= '0;
            digit_q       <= '0;
            load_pend_q   <= 1'b1;
            frame_start_q <= 1'b0;
            seg_q         <= 8'hFF;
            den_q         <= '1;
            sh_data_q     <= '0;
            sh_point_q    <= '0;
            sh_mask_q     <= '1;
            sh_supp_q     <= 1'b0;
            sh_bright_q   <= '0;
        end else begin
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            digit_q       <= digit_d;
            load_pend_q   <= load_pend_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            den_q         <= den_d;
            sh_data_q     <= sh_data_d;
            sh_point_q    <= sh_point_d;
            sh_mask_q     <= sh_mask_d;
            sh_supp_q     <= sh_supp_d;
            sh_bright_q   <= sh_bright_d;
        end
    end

    // The first load after reset holds the counters at zero so it lines up
    // with a frame-boundary load: both leave the scan at digit 0, slot 0.
    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        frame_wrap = tick && (slot_q == 4'hF) && (digit_q == DIGIT_LAST);
        load       = load_pend_q || frame_wrap;

        presc_d     = presc_q;
        slot_d      = slot_q;
        digit_d     = digit_q;
        load_pend_d = 1'b0;

        if (!load_pend_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                slot_d = slot_q + 1'b1;
                if (slot_q == 4'hF) begin
                    digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
                end
            end
        end

        frame_start_d = load;
        sh_data_d     = load ? data                 : sh_data_q;
        sh_point_d    = load ? pointEnable          : sh_point_q;
        sh_mask_d     = load ? digitMask            : sh_mask_q;
        sh_supp_d     = load ? suppressLeadingZeros : sh_supp_q;
        sh_bright_d   = load ? brightness           : sh_bright_q;
    end

    always_comb begin
        suppressed = '0;
        lead       = sh_supp_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead          = lead && (sh_data_q[4*i +: 4] == 4'h0) && !sh_point_q[i];
            suppressed[i] = lead;
        end
    end

    always_comb begin
        cur_nib  = '0;
        cur_pt   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                cur_nib  = sh_data_q[4*i +: 4];
                cur_pt   = sh_point_q[i];
                cur_dark = sh_mask_q[i] | suppressed[i];
            end
        end

        seg_d = cur_dark ? 8'hFF : {~cur_pt, hex_seg(cur_nib)[6:0]};

        // Slot 0 stays dark so segment changes never land under a lit digit.
        slot_lit = (slot_q != 4'h0) && (slot_q <= sh_bright_q);
        den_d    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_lit && (digit_q == DW'(i))) begin
                den_d[i] = 1'b0;
            end
        end
    end

    assign segmentEnableN = seg_q;
    assign digitEnableN   = den_q;
    assign frameStart     = frame_start_q;

endmodule
